uart_fifo_tx: RTL and testbench
===============================

Name: uart_fifo_tx

Overview:
- Serial transmitter that drains the FIFO from its read side and sends each popped word as an asynchronous frame: start bit, data bits LSB first, optional parity, stop bit(s).
- Sits between the FIFO (its read, empty and data_out signals) and the board TX pin.
- Pops words only on a one-cycle read strobe, so no word is lost or popped twice.

Parameters:
- DATA_WIDTH, 8: width of each FIFO word and number of data bits per frame.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new pops; a frame in flight always completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out; registered by the FIFO on the edge that samples fifo_read.
- fifo_read  out  1  pop strobe, one cycle per word, combinational from state and inputs.
- tx  out  1  serial line; idles high; registered.
- busy  out  1  high when state != IDLE.
- tx_done  out  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, tx=1, busy=0, tx_done=0, counters=0, shift register=0. fifo_read=0 while reset is high. A partially sent frame is aborted; the next frame starts from IDLE.
- States: IDLE, FETCH, START, DATA, (PARITY), STOP.
- IDLE:
  - fifo_read = enable & !fifo_empty.
  - If fifo_read is 1, go to FETCH on the next edge. The FIFO updates data_out on that same edge.
- FETCH, one cycle:
  - fifo_data is valid; latch it into the shift register.
  - Go to START.
  - tx stays 1.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
  - Shift right at the end of each bit period.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - In the last STOP cycle: tx_done=1.
  - If enable & !fifo_empty in that cycle: fifo_read=1 and the next state is FETCH (back-to-back frames, 1-cycle gap of tx=1).
  - Otherwise the next state is IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, clears on every state transition.
- Bit counter: $clog2(DATA_WIDTH+1) bits; also counts stop bits.
- fifo_read is asserted only in IDLE or the last STOP cycle. It is never asserted in two consecutive cycles.
- enable deasserted mid-frame: the current frame finishes; no further pop.
- fifo_empty is ignored outside the two pop points.
- Frame length, not counting FETCH: (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with PARITY_EN and 0 without.

Optional Feature:
- Macro: UART_FIFO_TX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA.
  - tx = XOR of all data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - The parity bit is computed from the word latched in FETCH.
- When undefined: no PARITY state; DATA goes straight to STOP; no parity logic is synthesized.

Test Plan:
1. Reset then idle with fifo_empty=1, enable=1 -> tx=1, busy=0, fifo_read never asserts over 100 cycles.
2. CLKS_PER_BIT=4, FIFO holds 0xA5, enable=1, read strobe at cycle 0 -> fifo_read high exactly cycle 0; FETCH cycle 1; tx=0 cycles 2-5; then bits 1,0,1,0,0,1,0,1 at 4 cycles each (cycles 6-37); tx=1 cycles 38-41; tx_done at cycle 41; exactly one pop.
3. FIFO holds 0x01,0xFF,0x00, enable=1 -> three frames; fifo_read in the last STOP cycle of frames 1 and 2; 1-cycle idle gap between frames; FIFO empty at the end; received bytes 0x01,0xFF,0x00 in order.
4. enable dropped in the middle of DATA, FIFO non-empty -> current frame completes with correct bits; no fifo_read; returns to IDLE with tx=1; resumes popping when enable rises.
5. reset asserted during bit 3 of DATA -> tx=1, busy=0 within the same cycle (asynchronous); after release, the next word pops from IDLE and its frame is correct.
6. With UART_FIFO_TX_PARITY_EN, send 0x07 -> parity bit 1 after the data bits; send 0x03 -> parity bit 0; frame length 11*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// ============================================================================
// Module  : uart_fifo_tx
// Brief   : Drains a FIFO one word per frame onto an async serial TX line.
//           Optional even-parity bit when UART_FIFO_TX_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_FIFO_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif

   logic [2:0]            state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
`ifdef UART_FIFO_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   logic baud_end;
   logic last_stop;
   logic pop_ok;

   assign baud_end  = (baud_q == BAUD_LAST);
   assign last_stop = (state_q == S_STOP) && baud_end && (bit_q == STOP_LAST);
   assign pop_ok    = enable && !fifo_empty && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_FIFO_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef UART_FIFO_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
`ifdef UART_FIFO_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (fifo_read) state_d = S_FETCH;
         end
         S_FETCH: begin
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = fifo_data;
`ifdef UART_FIFO_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
            state_d  = S_START;
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
`ifdef UART_FIFO_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
         end
`ifdef UART_FIFO_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = fifo_read ? S_FETCH : S_IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // tx is registered, so it is derived from the state being entered
   always_comb begin
      fifo_read = pop_ok && ((state_q == S_IDLE) || last_stop);
      busy      = (state_q != S_IDLE);
      tx_done   = last_stop;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_FIFO_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
// ============================================================================
// Module  : tb_uart_fifo_tx
// Brief   : Directed bench with FIFO model, serial receiver and scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_fifo_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef UART_FIFO_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB = 1 + DW + P + 1;
   localparam int FL = 1 + NB * CPB;

   typedef struct {
      logic [DW-1:0] data;
      logic          start_ok;
      logic          stop_ok;
      logic          par;
   } rx_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data  = '0;
   logic          fifo_read;
   logic          tx;
   logic          busy;
   logic          tx_done;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   rx_t           rx_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            pop_cnt  = 0;
   int            dbl_cnt  = 0;
   logic          prev_rd  = 1'b0;

   always #5 clk = ~clk;

   uart_fifo_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_read(fifo_read), .tx(tx), .busy(busy),
      .tx_done(tx_done)
   );

   // FIFO model: data_out registered on the popping edge, empty flag refreshed off-edge
   initial forever begin
      @(posedge clk);
      if (fifo_read === 1'b1 && fq.size() > 0) fifo_data <= fq.pop_front();
      #1 fifo_empty = (fq.size() == 0);
      @(negedge clk);
      #1 fifo_empty = (fq.size() == 0);
   end

   always @(posedge clk) begin
      if (fifo_read === 1'b1) pop_cnt++;
      if (fifo_read === 1'b1 && prev_rd === 1'b1) dbl_cnt++;
      prev_rd = fifo_read;
   end

   task automatic mon_wait(input int n, inout bit ab);
      repeat (n) begin
         if (ab) break;
         @(negedge clk);
         if (reset !== 1'b0) ab = 1'b1;
      end
   endtask

   // Serial receiver: samples mid-bit, drops frames cut short by reset
   initial forever begin
      bit  ab;
      rx_t r;
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      ab = 1'b0;
      r.par = 1'b0;
      mon_wait(1, ab);
      r.start_ok = (tx === 1'b0);
      for (int i = 0; i < DW; i++) begin
         mon_wait(CPB, ab);
         r.data[i] = tx;
      end
`ifdef UART_FIFO_TX_PARITY_EN
      mon_wait(CPB, ab);
      r.par = tx;
`endif
      mon_wait(CPB, ab);
      r.stop_ok = (tx === 1'b1);
      if (!ab) rx_q.push_back(r);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      while (busy !== 1'b0 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check(tag, busy, 0);
   endtask

   task automatic drain_rx();
      rx_t           r;
      logic [DW-1:0] e;
      while (rx_q.size() > 0) begin
         r = rx_q.pop_front();
         if (exp_q.size() == 0) begin
            check("sb_unexpected_frame", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("rx_data", r.data, e);
            check("rx_start", r.start_ok, 1);
            check("rx_stop", r.stop_ok, 1);
`ifdef UART_FIFO_TX_PARITY_EN
            check("rx_parity", r.par, ^e);
`endif
         end
      end
      check("sb_pending", exp_q.size(), 0);
   endtask

   initial begin
      int            base;
      int            bad;
      int            c;
      logic          et;
      logic [DW-1:0] w;

      // Test 1: reset values, then idle with an empty FIFO
      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_tx_done", tx_done, 0);
      check("rst_fifo_read", fifo_read, 0);
      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("idle_pop_cnt", pop_cnt, 0);
      check("idle_tx_busy_bad", bad, 0);

      // Test 2: exact frame timing for 0xA5
      w = 8'hA5;
      base = pop_cnt;
      push(w);
      #2;
      check("t2_read_k0", fifo_read, 1);
      check("t2_busy_k0", busy, 0);
      for (int k = 1; k <= FL + 1; k++) begin
         @(negedge clk);
         if (k < 2)                     et = 1'b1;
         else if (k < 6)                et = 1'b0;
         else if (k < 6 + DW * CPB)     et = w[(k - 6) / CPB];
         else if (k < 6 + (DW + P) * CPB) et = ^w;
         else                           et = 1'b1;
         check($sformatf("t2_tx_k%0d", k), tx, et);
         check($sformatf("t2_done_k%0d", k), tx_done, (k == FL));
         check($sformatf("t2_read_k%0d", k), fifo_read, 0);
         check($sformatf("t2_busy_k%0d", k), busy, (k <= FL));
      end
      check("t2_pops", pop_cnt - base, 1);
      drain_rx();

      // Test 3: three back-to-back frames
      base = pop_cnt;
      push(8'h01);
      push(8'hFF);
      push(8'h00);
      @(negedge clk);
      c = 0;
      while (busy === 1'b1 && c < 1000) begin
         c++;
         @(negedge clk);
      end
      check("t3_busy_cycles", c, 3 * FL);
      check("t3_pops", pop_cnt - base, 3);
      check("t3_double_read", dbl_cnt, 0);
      check("t3_fifo_left", fq.size(), 0);
      repeat (3) @(negedge clk);
      drain_rx();

      // Test 4: enable dropped mid-DATA
      base = pop_cnt;
      push(8'h3C);
      push(8'h5A);
      repeat (15) @(negedge clk);
      enable = 1'b0;
      wait_idle("t4_timeout_a");
      check("t4_pops_a", pop_cnt - base, 1);
      check("t4_fifo_left", fq.size(), 1);
      repeat (20) @(negedge clk);
      check("t4_idle_busy", busy, 0);
      check("t4_idle_tx", tx, 1);
      check("t4_pops_b", pop_cnt - base, 1);
      enable = 1'b1;
      #2;
      check("t4_resume_read", fifo_read, 1);
      @(negedge clk);
      wait_idle("t4_timeout_b");
      check("t4_pops_c", pop_cnt - base, 2);
      repeat (3) @(negedge clk);
      drain_rx();

      // Test 5: asynchronous reset during data bit 3
      base = pop_cnt;
      push(8'h96);
      repeat (19) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("t5_async_tx", tx, 1);
      check("t5_async_busy", busy, 0);
      void'(exp_q.pop_back());
      push(8'hC3);
      repeat (3) @(negedge clk);
      check("t5_rst_read", fifo_read, 0);
      check("t5_rst_busy", busy, 0);
      reset = 1'b0;
      #2;
      check("t5_repop_read", fifo_read, 1);
      @(negedge clk);
      wait_idle("t5_timeout");
      check("t5_pops", pop_cnt - base, 2);
      repeat (3) @(negedge clk);
      drain_rx();

`ifdef UART_FIFO_TX_PARITY_EN
      // Test 6: parity bit and frame length
      push(8'h07);
      @(negedge clk);
      c = 0;
      while (busy === 1'b1 && c < 1000) begin
         c++;
         @(negedge clk);
      end
      check("t6_frame_len", c, 1 + 11 * CPB);
      push(8'h03);
      @(negedge clk);
      wait_idle("t6_timeout");
      repeat (3) @(negedge clk);
      drain_rx();
`endif

      check("final_double_read", dbl_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
